// File: rtl/apb_master_bridge.sv
// APB requester: runs one SETUP/ACCESS transfer per accepted command and returns the result on a response port.
// Optional ACCESS timeout: define APB_MASTER_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | bus idle, cmd_ready high (except first cycle after reset)
// SETUP  | Pselx=1, Penable=0 for one cycle
// ACCESS | Pselx=1, Penable=1 until Pready (or timeout abort)
// RESP   | response held until rsp_ready
module apb_master_bridge #(
    parameter int ADDR_WIDTH     = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  Pclk,
    input  logic                  Prst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [15:0]           xfer_count,
    output logic                  Pselx,
    output logic                  Penable,
    output logic                  Pwrite,
    output logic [ADDR_WIDTH-1:0] Paddr,
    output logic [DATA_WIDTH-1:0] Pwdata,
    input  logic                  Pready,
    input  logic                  Pslverr,
    input  logic [DATA_WIDTH-1:0] Prdata
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                  state, state_nxt;
    logic                    cmd_ready_nxt, rsp_valid_nxt, rsp_err_nxt;
    logic                    pselx_nxt, penable_nxt, pwrite_nxt;
    logic [DATA_WIDTH-1:0]   rsp_rdata_nxt, pwdata_nxt;
    logic [ADDR_WIDTH-1:0]   paddr_nxt;
    logic [15:0]             xfer_count_nxt;
    logic                    tmo_hit;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    // Down-counter loaded on entry to ACCESS; terminal count marks the last allowed wait cycle.
    logic [TW-1:0] tmo_cnt, tmo_cnt_nxt;
    assign tmo_hit = (tmo_cnt == '0);

    always_ff @(posedge Pclk or negedge Prst) begin
        if (!Prst) tmo_cnt <= '0;
        else       tmo_cnt <= tmo_cnt_nxt;
    end

    always_comb begin
        tmo_cnt_nxt = tmo_cnt;
        if (state == SETUP)
            tmo_cnt_nxt = TW'(TIMEOUT_CYCLES - 1);
        else if (state == ACCESS && !Pready && !tmo_hit)
            tmo_cnt_nxt = tmo_cnt - 1'b1;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_nxt      = state;
        cmd_ready_nxt  = cmd_ready;
        rsp_valid_nxt  = rsp_valid;
        rsp_rdata_nxt  = rsp_rdata;
        rsp_err_nxt    = rsp_err;
        xfer_count_nxt = xfer_count;
        pselx_nxt      = Pselx;
        penable_nxt    = Penable;
        pwrite_nxt     = Pwrite;
        paddr_nxt      = Paddr;
        pwdata_nxt     = Pwdata;
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    pwrite_nxt    = cmd_write;
                    paddr_nxt     = cmd_addr;
                    if (cmd_write) pwdata_nxt = cmd_wdata;
                    pselx_nxt     = 1'b1;
                    cmd_ready_nxt = 1'b0;
                    state_nxt     = SETUP;
                end else begin
                    cmd_ready_nxt = 1'b1;
                end
            end
            SETUP: begin
                penable_nxt = 1'b1;
                state_nxt   = ACCESS;
            end
            ACCESS: begin
                if (Pready) begin
                    rsp_rdata_nxt  = Pwrite ? '0 : Prdata;
                    rsp_err_nxt    = Pslverr;
                    pselx_nxt      = 1'b0;
                    penable_nxt    = 1'b0;
                    rsp_valid_nxt  = 1'b1;
                    xfer_count_nxt = xfer_count + 16'd1;
                    state_nxt      = RESP;
                end else if (tmo_hit) begin
                    rsp_rdata_nxt = '0;
                    rsp_err_nxt   = 1'b1;
                    pselx_nxt     = 1'b0;
                    penable_nxt   = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    cmd_ready_nxt = 1'b1;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Pclk or negedge Prst) begin
        if (!Prst) begin
            state      <= IDLE;
            cmd_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            xfer_count <= '0;
            Pselx      <= 1'b0;
            Penable    <= 1'b0;
            Pwrite     <= 1'b0;
            Paddr      <= '0;
            Pwdata     <= '0;
        end else begin
            state      <= state_nxt;
            cmd_ready  <= cmd_ready_nxt;
            rsp_valid  <= rsp_valid_nxt;
            rsp_rdata  <= rsp_rdata_nxt;
            rsp_err    <= rsp_err_nxt;
            xfer_count <= xfer_count_nxt;
            Pselx      <= pselx_nxt;
            Penable    <= penable_nxt;
            Pwrite     <= pwrite_nxt;
            Paddr      <= paddr_nxt;
            Pwdata     <= pwdata_nxt;
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with a 32-word APB memory model and configurable wait states.
module tb_apb_master_bridge;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          Pclk = 1'b0;
    logic          Prst = 1'b0;
    logic          cmd_valid, cmd_write, rsp_ready;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          cmd_ready, rsp_valid, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic [15:0]   xfer_count;
    logic          Pselx, Penable, Pwrite, Pready, Pslverr;
    logic [AW-1:0] Paddr;
    logic [DW-1:0] Pwdata, Prdata;

    always #5 Pclk = ~Pclk;

    apb_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
        .Pclk(Pclk), .Prst(Prst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .xfer_count(xfer_count),
        .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite), .Paddr(Paddr),
        .Pwdata(Pwdata), .Pready(Pready), .Pslverr(Pslverr), .Prdata(Prdata)
    );

    // Memory slave: ready after waits_cfg wait cycles, error flag only on the completing cycle.
    logic [DW-1:0] mem [32];
    int            waits_cfg = 0;
    logic          slverr_cfg = 1'b0;
    int            wait_cnt = 0;

    assign Pready  = Pselx && Penable && (wait_cnt >= waits_cfg);
    assign Pslverr = slverr_cfg && Pready;
    assign Prdata  = mem[Paddr];

    always @(posedge Pclk) begin
        if (!Prst) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
        end else if (Pselx && Penable && Pready && Pwrite) begin
            mem[Paddr] <= Pwdata;
        end
        if (Pselx && Penable && !Pready) wait_cnt <= wait_cnt + 1;
        else                             wait_cnt <= 0;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            waits;
        logic          serr;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        logic [DW-1:0] exp_pwdata;
    } vec_t;

    vec_t vecs[7];

    // Issue one command and follow it to the response; leaves the bench at the negedge where rsp_valid is seen.
    task automatic do_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           output int lat, output int pen, output logic [DW-1:0] pwd0,
                           output logic stable, output logic setup_ok);
        int guard = 0;
        @(negedge Pclk);
        while (!cmd_ready && guard < 20) begin
            @(negedge Pclk);
            guard++;
        end
        chk("cmd_ready_before_cmd", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        @(posedge Pclk);
        #1;
        cmd_valid = 1'b0;
        cmd_wdata = 32'h5555_AAAA;
        lat = 0; pen = 0; stable = 1'b1; setup_ok = 1'b0; pwd0 = '0;
        do begin
            @(negedge Pclk);
            lat++;
            if (lat == 1) begin
                setup_ok = Pselx && !Penable;
                pwd0     = Pwdata;
            end
            if (Penable) pen++;
            if (Pselx && Paddr !== addr) stable = 1'b0;
        end while (!rsp_valid && lat < 60);
        chk("rsp_valid_seen", 32'(rsp_valid), 32'd1);
    endtask

    int            lat, pen, exp_count;
    logic [DW-1:0] pwd0;
    logic          stable, setup_ok;

    initial begin
        vecs[0] = '{1'b1, 5'd5,  32'hDEAD_BEEF, 0, 1'b0, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
        vecs[1] = '{1'b0, 5'd5,  32'h0000_0000, 0, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 5'd31, 32'h1234_5678, 3, 1'b1, 32'h0000_0000, 1'b1, 32'h1234_5678};
        vecs[3] = '{1'b0, 5'd31, 32'hFFFF_FFFF, 1, 1'b0, 32'h1234_5678, 1'b0, 32'h1234_5678};
        vecs[4] = '{1'b1, 5'd0,  32'hA5A5_A5A5, 0, 1'b0, 32'h0000_0000, 1'b0, 32'hA5A5_A5A5};
        vecs[5] = '{1'b0, 5'd0,  32'h0000_0000, 2, 1'b1, 32'hA5A5_A5A5, 1'b1, 32'hA5A5_A5A5};
        vecs[6] = '{1'b0, 5'd7,  32'h0000_0000, 0, 1'b0, 32'hC0DE_0007, 1'b0, 32'hA5A5_A5A5};

        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b1;
        exp_count = 0;

        // Reset state
        #23;
        chk("reset_ctrl", 32'({cmd_ready, rsp_valid, Pselx, Penable, Pwrite, rsp_err}), 32'd0);
        chk("reset_paddr", 32'(Paddr), 32'd0);
        chk("reset_pwdata", Pwdata, 32'd0);
        chk("reset_rdata", rsp_rdata, 32'd0);
        chk("reset_count", 32'(xfer_count), 32'd0);
        @(negedge Pclk);
        Prst = 1'b1;
        #1;
        chk("cmd_ready_first_cycle", 32'(cmd_ready), 32'd0);
        @(negedge Pclk);
        chk("cmd_ready_after_first_edge", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 7; i++) begin
            waits_cfg  = vecs[i].waits;
            slverr_cfg = vecs[i].serr;
            do_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, pen, pwd0, stable, setup_ok);
            exp_count++;
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(3 + vecs[i].waits));
            chk($sformatf("v%0d_penable_cycles", i), 32'(pen), 32'(1 + vecs[i].waits));
            chk($sformatf("v%0d_setup_phase", i), 32'(setup_ok), 32'd1);
            chk($sformatf("v%0d_paddr_stable", i), 32'(stable), 32'd1);
            chk($sformatf("v%0d_pwdata", i), pwd0, vecs[i].exp_pwdata);
            chk($sformatf("v%0d_rdata", i), rsp_rdata, vecs[i].exp_rdata);
            chk($sformatf("v%0d_err", i), 32'(rsp_err), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d_count", i), 32'(xfer_count), 32'(exp_count));
            @(negedge Pclk);
            chk($sformatf("v%0d_after_rsp", i), 32'({rsp_valid, Pselx, cmd_ready}), 32'b001);
        end
        slverr_cfg = 1'b0;
        waits_cfg  = 0;

        // Response back-pressure with a pending command
        rsp_ready = 1'b0;
        do_xfer(1'b0, 5'd5, 32'h0, lat, pen, pwd0, stable, setup_ok);
        exp_count++;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'd3; cmd_wdata = 32'h0BAD_0003;
        for (int k = 0; k < 5; k++) begin
            @(negedge Pclk);
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rdata", rsp_rdata, 32'hDEAD_BEEF);
            chk("hold_err", 32'(rsp_err), 32'd0);
            chk("hold_no_accept", 32'({cmd_ready, Pselx}), 32'd0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge Pclk);
        chk("hold_release", 32'({rsp_valid, cmd_ready}), 32'b01);
        chk("hold_count", 32'(xfer_count), 32'(exp_count));

        // Asynchronous reset during ACCESS
        waits_cfg = 10;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'd9; cmd_wdata = 32'h0BAD_F00D;
        @(posedge Pclk);
        #1 cmd_valid = 1'b0;
        @(negedge Pclk);
        @(negedge Pclk);
        chk("in_access", 32'({Pselx, Penable}), 32'b11);
        #2 Prst = 1'b0;
        #1;
        chk("async_rst_bus", 32'({Pselx, Penable, rsp_valid}), 32'd0);
        chk("async_rst_count", 32'(xfer_count), 32'd0);
        @(negedge Pclk);
        Prst = 1'b1;
        exp_count = 0;
        waits_cfg = 0;
        do_xfer(1'b0, 5'd9, 32'h0, lat, pen, pwd0, stable, setup_ok);
        exp_count++;
        chk("post_rst_latency", 32'(lat), 32'd3);
        chk("post_rst_rdata", rsp_rdata, 32'hC0DE_0009);
        chk("post_rst_count", 32'(xfer_count), 32'(exp_count));
        @(negedge Pclk);

`ifdef APB_MASTER_TIMEOUT_EN
        waits_cfg = 100;
        do_xfer(1'b0, 5'd2, 32'h0, lat, pen, pwd0, stable, setup_ok);
        chk("tmo_latency", 32'(lat), 32'd18);
        chk("tmo_penable_cycles", 32'(pen), 32'd16);
        chk("tmo_err", 32'(rsp_err), 32'd1);
        chk("tmo_rdata", rsp_rdata, 32'd0);
        chk("tmo_count", 32'(xfer_count), 32'(exp_count));
        @(negedge Pclk);
        waits_cfg = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
